inv_substitution_seq: RTL and testbench



---
 rtl/inv_substitution_seq.sv | 136 +++++++++++++
 tb/tb_inv_substitution_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_substitution_seq.sv
// Iterative ASCON inverse substitution layer: COLS_PER_CYCLE S-box columns per clock.
// Optional macro SUBST_FWD_MODE_EN adds mode_i to select the forward S-box per operation.
module inv_substitution_seq #(
    parameter int unsigned COLS_PER_CYCLE = 8
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
`ifdef SUBST_FWD_MODE_EN
    input  logic             mode_i,
`endif
    input  logic [4:0][63:0] registerS_i,
    output logic [4:0][63:0] registerS_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned NUM_SLICES = 64 / COLS_PER_CYCLE;
    localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

    // Tables packed with entry 31 first so that TABLE[idx] selects entry idx.
    localparam logic [31:0][4:0] INV_SBOX = {
        5'h02, 5'h10, 5'h0C, 5'h0F, 5'h08, 5'h04, 5'h1B, 5'h17,
        5'h1F, 5'h1C, 5'h05, 5'h03, 5'h11, 5'h0B, 5'h16, 5'h18,
        5'h1E, 5'h13, 5'h15, 5'h19, 5'h01, 5'h1D, 5'h06, 5'h0A,
        5'h12, 5'h0E, 5'h09, 5'h00, 5'h0D, 5'h07, 5'h1A, 5'h14
    };
`ifdef SUBST_FWD_MODE_EN
    localparam logic [31:0][4:0] FWD_SBOX = {
        5'h17, 5'h0F, 5'h0A, 5'h16, 5'h19, 5'h01, 5'h0C, 5'h10,
        5'h18, 5'h11, 5'h0D, 5'h00, 5'h0E, 5'h07, 5'h13, 5'h1E,
        5'h1C, 5'h06, 5'h03, 5'h1D, 5'h12, 5'h08, 5'h05, 5'h1B,
        5'h02, 5'h09, 5'h15, 5'h1A, 5'h14, 5'h1F, 5'h0B, 5'h04
    };
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           stateQ, stateNext;
    logic [CNT_W-1:0] counterQ, counterNext;
    logic [4:0][63:0] regNext, sliceResult;
    logic             busyNext, doneNext;
    logic [5:0]       sliceBase, col;
    logic [4:0]       colIdx, colSub;
`ifdef SUBST_FWD_MODE_EN
    logic             modeQ, modeNext;
`endif

    // Substitute the current slice of columns in place; row 0 is the index MSB.
    always_comb begin
        sliceResult = registerS_o;
        sliceBase   = 6'(32'(counterQ) * COLS_PER_CYCLE);
        col         = '0;
        colIdx      = '0;
        colSub      = '0;
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            col    = sliceBase + 6'(k);
            colIdx = {registerS_o[0][col], registerS_o[1][col], registerS_o[2][col],
                      registerS_o[3][col], registerS_o[4][col]};
`ifdef SUBST_FWD_MODE_EN
            colSub = modeQ ? FWD_SBOX[colIdx] : INV_SBOX[colIdx];
`else
            colSub = INV_SBOX[colIdx];
`endif
            sliceResult[0][col] = colSub[4];
            sliceResult[1][col] = colSub[3];
            sliceResult[2][col] = colSub[2];
            sliceResult[3][col] = colSub[1];
            sliceResult[4][col] = colSub[0];
        end
    end

    // Next-state, counter and datapath selection.
    always_comb begin
        stateNext   = stateQ;
        counterNext = counterQ;
        regNext     = registerS_o;
`ifdef SUBST_FWD_MODE_EN
        modeNext    = modeQ;
`endif
        case (stateQ)
            IDLE, DONE: begin
                if (start_i) begin
                    regNext     = registerS_i;
                    counterNext = '0;
                    stateNext   = RUN;
`ifdef SUBST_FWD_MODE_EN
                    modeNext    = mode_i;
`endif
                end else begin
                    stateNext = IDLE;
                end
            end
            RUN: begin
                regNext = sliceResult;
                if (counterQ == LAST_SLICE) begin
                    counterNext = '0;
                    stateNext   = DONE;
                end else begin
                    counterNext = counterQ + CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext == RUN);
        doneNext = (stateNext == DONE);
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            stateQ      <= IDLE;
            counterQ    <= '0;
            registerS_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
`ifdef SUBST_FWD_MODE_EN
            modeQ       <= 1'b0;
`endif
        end else begin
            stateQ      <= stateNext;
            counterQ    <= counterNext;
            registerS_o <= regNext;
            busy_o      <= busyNext;
            done_o      <= doneNext;
`ifdef SUBST_FWD_MODE_EN
            modeQ       <= modeNext;
`endif
        end
    end

endmodule

// File: tb/tb_inv_substitution_seq.sv
// Scoreboard bench for inv_substitution_seq at 8, 1 and 64 columns per cycle.
// Build with SUBST_FWD_MODE_EN defined to also exercise the forward mode.
module tb_inv_substitution_seq;

    typedef logic [4:0][63:0] state_t;
    typedef struct {
        int unsigned cyc;
        state_t      val;
    } exp_t;

    localparam int LAT [3] = '{8, 64, 1};

    logic [4:0] invTab [32] = '{5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
                                5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
                                5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
                                5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02};
    logic [4:0] fwdTab [32] = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                                5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                                5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                                5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        start [3];
    state_t      regIn;
    state_t      regOut [3];
    logic        busy [3];
    logic        done [3];
`ifdef SUBST_FWD_MODE_EN
    logic        modeIn = 1'b0;
`endif
    int unsigned cyc = 0;
    int          nCmp = 0;
    int          nMis = 0;
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_substitution_seq #(.COLS_PER_CYCLE(8)) dut8 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start[0]),
`ifdef SUBST_FWD_MODE_EN
        .mode_i(modeIn),
`endif
        .registerS_i(regIn), .registerS_o(regOut[0]), .busy_o(busy[0]), .done_o(done[0]));

    inv_substitution_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start[1]),
`ifdef SUBST_FWD_MODE_EN
        .mode_i(modeIn),
`endif
        .registerS_i(regIn), .registerS_o(regOut[1]), .busy_o(busy[1]), .done_o(done[1]));

    inv_substitution_seq #(.COLS_PER_CYCLE(64)) dut64 (
        .clock_i(clk), .resetb_i(resetb), .start_i(start[2]),
`ifdef SUBST_FWD_MODE_EN
        .mode_i(modeIn),
`endif
        .registerS_i(regIn), .registerS_o(regOut[2]), .busy_o(busy[2]), .done_o(done[2]));

    // Reference: every column index goes through the table, row 0 is the MSB.
    function automatic state_t subst(input state_t s, input logic useFwd);
        state_t     r;
        logic [4:0] v;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            v = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
            v = useFwd ? fwdTab[v] : invTab[v];
            for (int row = 0; row < 5; row++) r[row][i] = v[4-row];
        end
        return r;
    endfunction

    function automatic state_t randState();
        state_t s;
        for (int row = 0; row < 5; row++) s[row] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic cmp(input string name, input logic [319:0] act, input logic [319:0] req);
        nCmp++;
        if (act !== req) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic monCheck(input int i);
        exp_t e;
        bit   have;
        have = 0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
        endcase
        if (!have) begin
            cmp($sformatf("unexpected_done_dut%0d", i), 1, 0);
        end else begin
            cmp($sformatf("done_cycle_dut%0d", i), cyc, e.cyc);
            cmp($sformatf("result_dut%0d", i), regOut[i], e.val);
            cmp($sformatf("busy_at_done_dut%0d", i), busy[i], 0);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetb) begin
            for (int i = 0; i < 3; i++) if (done[i]) monCheck(i);
        end
    end

    task automatic issue(input logic [2:0] mask, input state_t d, input logic m);
        exp_t e;
        @(negedge clk);
        regIn = d;
`ifdef SUBST_FWD_MODE_EN
        modeIn = m;
`endif
        for (int i = 0; i < 3; i++) start[i] = mask[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        regIn = randState();
`ifdef SUBST_FWD_MODE_EN
        modeIn = ~m;
`endif
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                e.cyc = cyc + LAT[i];
                e.val = subst(d, m);
                case (i)
                    0: q0.push_back(e);
                    1: q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        cmp("drain_outstanding", q0.size() + q1.size() + q2.size(), 0);
    endtask

    initial begin
        state_t pat, first, a;
        int     cnt;
        logic   m;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        regIn = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("reset_reg_dut%0d", i), regOut[i], '0);
            cmp($sformatf("reset_busy_dut%0d", i), busy[i], 0);
            cmp($sformatf("reset_done_dut%0d", i), done[i], 0);
        end
        @(negedge clk);
        resetb = 1'b1;

        // All-zero state: every column 0x00 -> 0x14, i.e. rows 0 and 2 all ones.
        issue(3'b001, '0, 1'b0);
        waitDrain();
        cmp("allzero_const", regOut[0], {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                                         64'hFFFF_FFFF_FFFF_FFFF});

        // Every column 0x04 -> all zero; busy must span exactly 8 cycles.
        a = '0;
        a[2] = '1;
        issue(3'b001, a, 1'b0);
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done[0]) break;
            if (busy[0]) cnt++;
        end
        cmp("busy_cycles", cnt, 8);
        waitDrain();
        cmp("col04_const", regOut[0], '0);

        // Column i holds i mod 32, on all three widths; forward S-box must undo it.
        for (int i = 0; i < 64; i++)
            for (int row = 0; row < 5; row++) pat[row][i] = 1'((i % 32) >> (4 - row));
        issue(3'b111, pat, 1'b0);
        waitDrain();
        for (int i = 0; i < 3; i++)
            cmp($sformatf("fwd_roundtrip_dut%0d", i), subst(regOut[i], 1'b1), pat);

        // start during RUN is ignored.
        first = randState();
        issue(3'b001, first, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        regIn = randState();
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        waitDrain();
        repeat (12) @(posedge clk);

        // start during DONE restarts immediately.
        issue(3'b001, randState(), 1'b0);
        repeat (8) @(posedge clk);
        issue(3'b001, randState(), 1'b0);
        waitDrain();

        // Reset mid-run discards the operation.
        issue(3'b001, randState(), 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        resetb = 1'b0;
        #1;
        cmp("midreset_reg", regOut[0], '0);
        cmp("midreset_busy", busy[0], 0);
        cmp("midreset_done", done[0], 0);
        q0.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
        repeat (12) @(posedge clk);
        issue(3'b001, randState(), 1'b0);
        waitDrain();

`ifdef SUBST_FWD_MODE_EN
        issue(3'b001, '0, 1'b1);
        waitDrain();
        a = '0;
        a[2] = '1;
        cmp("fwd_allzero_const", regOut[0], a);
        issue(3'b001, regOut[0], 1'b0);
        waitDrain();
        cmp("fwd_back_const", regOut[0], '0);
`endif

        // Randomized traffic with random gaps on every width.
        for (int n = 0; n < 30; n++) begin
`ifdef SUBST_FWD_MODE_EN
            m = 1'($urandom_range(1, 0));
`else
            m = 1'b0;
`endif
            issue(3'($urandom_range(7, 1)), randState(), m);
            waitDrain();
            repeat ($urandom_range(3, 0)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", nCmp);
        $fatal(1, "timeout");
    end

endmodule
